fwd_scoreboard: RTL and testbench
=================================

// Module: fwd_scoreboard
// PURPOSE
//  Parametrised operand-bypass controller for the pipelined datapath. Tracks the last
//  DEPTH issued instructions in a shift-register scoreboard and, per source operand of
//  the instruction in ID, selects the youngest in-flight producer or the register file.
//  Detects load-use hazards, raises stall and inserts a bubble. Keeps a stall counter.
// PARAMETERS
//  REG_AW    5   register-address width (register 0 is hardwired zero)
//  NUM_SRC   2   source operands per instruction
//  DEPTH     2   tracked in-flight stages (entry 0 = youngest, i.e. EX)
//  LOAD_LAT  1   first entry index whose bypass bus carries load data
//  CNT_W     16  stall-counter width
// PORTS
//  clk        in   1                  rising-edge clock
//  rst        in   1                  synchronous active-high reset
//  id_valid   in   1                  ID holds a real instruction for issue
//  id_dst     in   REG_AW             destination register of the ID instruction
//  id_regwr   in   1                  ID instruction writes a register
//  id_memrd   in   1                  ID instruction is a load
//  id_src     in   NUM_SRC*REG_AW     source addresses, src j at [j*REG_AW +: REG_AW]
//  id_src_use in   NUM_SRC            src j actually read by the ID instruction
//  flush      in   1                  squash the ID instruction (branch taken)
//  fwd_sel    out  NUM_SRC*SW         SW=$clog2(DEPTH+1); 0=regfile, k+1=bypass bus k
//  stall      out  1                  hold PC and IF/ID, insert bubble into EX
//  stall_cnt  out  CNT_W              cycles with stall=1, saturating
// BEHAVIOUR
//  - State: DEPTH entries {v, dst, ld}. Registers only; outputs fwd_sel/stall are
//    combinational from state and ID inputs; stall_cnt is a register.
//  - Reset (rst=1 at edge): all v=0, stall_cnt=0; hence fwd_sel=0, stall=0 after.
//  - Match for src j at entry k: id_src_use[j] && v[k] && dst[k]==src_j && src_j!=0.
//  - fwd_sel[j] = (lowest matching k)+1, else 0. Youngest producer always wins.
//  - Entry k is "pending" if ld[k] && k<LOAD_LAT. stall = id_valid && !flush && some
//    src's lowest matching entry is pending. A pending entry blocks and is not skipped.
//    Older matches do not unblock it.
//  - Each edge (rst=0): entry[k+1] <= entry[k] for k<DEPTH-1. The oldest entry is
//    discarded because its result is in the regfile. New entry[0]:
//    * if id_valid && !stall && !flush: {id_regwr && id_dst!=0, id_dst, id_memrd}
//    * otherwise a bubble: v=0.
//  - The pipeline never freezes the scoreboard. A stall always shifts plus bubble, so
//    a load in entry 0 moves to entry 1 and the stall clears after LOAD_LAT cycles.
//  - flush has priority over stall. The squashed instruction is not recorded, and
//    stall=0 in that cycle.
//  - id_valid=0: stall=0, bubble inserted. fwd_sel is still driven, and is don't-care.
//  - stall_cnt increments on each edge where stall=1. It holds at 2^CNT_W-1.
//  - LOAD_LAT=0: loads never stall. LOAD_LAT>=DEPTH: a load stalls until it leaves.
//  - rst mid-stall: the scoreboard clears, so stall deasserts the next cycle.
//  - Both srcs equal: each gets an identical fwd_sel.
// TESTING (defaults unless noted)
//  1 add r3 issued; next ID add r4,r3,r3 -> fwd_sel={2'd1,2'd1}, stall=0.
//  2 lw r5 issued; next ID uses r5 -> stall=1 for 1 cycle, stall_cnt=1; next cycle
//    fwd_sel for r5 =2, stall=0.
//  3 add r7; add r7; ID reads r7 -> fwd_sel=1, not 2 (youngest wins).
//  4 Writer to r0, or id_regwr=0, then ID reads r0 -> fwd_sel=0, stall=0.
//  5 lw r5 in entry 0, flush=1 with ID reading r5 -> stall=0, no entry recorded;
//    next ID reading r5 -> fwd_sel=2.
//  6 DEPTH=4,LOAD_LAT=2,CNT_W=2: lw r9, then 5 stall-inducing loads -> 2-cycle stalls,
//    stall_cnt saturates at 3; rst mid-stall -> stall=0, stall_cnt=0 next cycle.

Source files
------------

// File: rtl/fwd_scoreboard_if.sv
// Issue-stage bundle between the ID stage and the operand-bypass controller.
interface fwd_scoreboard_if #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned CNT_W   = 16
);
    localparam int unsigned SW = $clog2(DEPTH + 1);

    logic                      id_valid;
    logic [REG_AW-1:0]         id_dst;
    logic                      id_regwr;
    logic                      id_memrd;
    logic [NUM_SRC*REG_AW-1:0] id_src;
    logic [NUM_SRC-1:0]        id_src_use;
    logic                      flush;
    logic [NUM_SRC*SW-1:0]     fwd_sel;
    logic                      stall;
    logic [CNT_W-1:0]          stall_cnt;

    modport master (
        output id_valid, id_dst, id_regwr, id_memrd, id_src, id_src_use, flush,
        input  fwd_sel, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_dst, id_regwr, id_memrd, id_src, id_src_use, flush,
        output fwd_sel, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Operand-bypass controller: shift-register scoreboard of in-flight producers,
// per-source bypass select, load-use stall detection and a saturating stall counter.
module fwd_scoreboard #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input logic              clk,
    input logic              rst,
    fwd_scoreboard_if.slave  bus
);
    localparam int unsigned SW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]      ent_v;
    logic [DEPTH-1:0]      ent_ld;
    logic [REG_AW-1:0]     ent_dst [DEPTH];
    logic [NUM_SRC*SW-1:0] sel;
    logic [NUM_SRC-1:0]    blk;
    logic                  stall;
    logic                  accept;
    logic [CNT_W-1:0]      cnt;

    // Per source: scan oldest to youngest so the youngest match overwrites;
    // the blocking flag follows that same match, so older entries never unblock it.
    always_comb begin
        sel = '0;
        blk = '0;
        for (int unsigned j = 0; j < NUM_SRC; j++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (bus.id_src_use[j] && ent_v[DEPTH-1-i] &&
                    (ent_dst[DEPTH-1-i] == bus.id_src[j*REG_AW +: REG_AW]) &&
                    (bus.id_src[j*REG_AW +: REG_AW] != '0)) begin
                    sel[j*SW +: SW] = SW'(DEPTH - i);
                    blk[j]          = ent_ld[DEPTH-1-i] && ((DEPTH - 1 - i) < LOAD_LAT);
                end
            end
        end
    end

    // Flush wins over stall; only a real, unsquashed, unstalled instruction is recorded.
    always_comb begin
        stall  = bus.id_valid && !bus.flush && (|blk);
        accept = bus.id_valid && !bus.flush && !stall;
    end

    assign bus.fwd_sel   = sel;
    assign bus.stall     = stall;
    assign bus.stall_cnt = cnt;

    // Scoreboard always shifts; a stalled or squashed slot enters as a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_v  <= '0;
            ent_ld <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                ent_dst[k] <= '0;
            end
        end else begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                ent_v[k]   <= ent_v[k-1];
                ent_ld[k]  <= ent_ld[k-1];
                ent_dst[k] <= ent_dst[k-1];
            end
            ent_v[0]   <= accept && bus.id_regwr && (bus.id_dst != '0);
            ent_ld[0]  <= accept && bus.id_memrd;
            ent_dst[0] <= bus.id_dst;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (stall && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: default configuration and a deep
// configuration (DEPTH=4, LOAD_LAT=2, CNT_W=2) checked through a queue of expectations.
module tb_fwd_scoreboard;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    fwd_scoreboard_if #(.REG_AW(5), .NUM_SRC(2), .DEPTH(2), .CNT_W(16)) ia ();
    fwd_scoreboard_if #(.REG_AW(5), .NUM_SRC(2), .DEPTH(4), .CNT_W(2))  ib ();

    fwd_scoreboard #(.REG_AW(5), .NUM_SRC(2), .DEPTH(2), .LOAD_LAT(1), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ia)
    );

    fwd_scoreboard #(.REG_AW(5), .NUM_SRC(2), .DEPTH(4), .LOAD_LAT(2), .CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ib)
    );

    typedef struct {
        string       tag;
        logic [5:0]  sel;
        logic        stall;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // One issue cycle: drive ID, queue the expectation, compare mid-cycle, advance.
    task automatic step(input bit b, input logic v, input logic [4:0] dst,
                        input logic regwr, input logic memrd,
                        input logic [4:0] s1, input logic [4:0] s0,
                        input logic [1:0] use_m, input logic fl,
                        input logic [5:0] e_sel, input logic e_stall,
                        input logic [15:0] e_cnt, input string tag);
        exp_t        e;
        logic [5:0]  o_sel;
        logic        o_stall;
        logic [15:0] o_cnt;
        if (b) begin
            ib.id_valid = v; ib.id_dst = dst; ib.id_regwr = regwr; ib.id_memrd = memrd;
            ib.id_src = {s1, s0}; ib.id_src_use = use_m; ib.flush = fl;
        end else begin
            ia.id_valid = v; ia.id_dst = dst; ia.id_regwr = regwr; ia.id_memrd = memrd;
            ia.id_src = {s1, s0}; ia.id_src_use = use_m; ia.flush = fl;
        end
        q.push_back('{tag, e_sel, e_stall, e_cnt});
        @(negedge clk);
        if (b) begin
            o_sel = ib.fwd_sel; o_stall = ib.stall; o_cnt = {14'd0, ib.stall_cnt};
        end else begin
            o_sel = {2'b00, ia.fwd_sel}; o_stall = ia.stall; o_cnt = ia.stall_cnt;
        end
        e = q.pop_front();
        n_chk++;
        assert (o_sel === e.sel) n_pass++;
        else $error("FAIL %s.fwd_sel got=%b exp=%b", e.tag, o_sel, e.sel);
        n_chk++;
        assert (o_stall === e.stall) n_pass++;
        else $error("FAIL %s.stall got=%b exp=%b", e.tag, o_stall, e.stall);
        n_chk++;
        assert (o_cnt === e.cnt) n_pass++;
        else $error("FAIL %s.stall_cnt got=%0d exp=%0d", e.tag, o_cnt, e.cnt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] c;
        ia.id_valid = 0; ia.id_dst = 0; ia.id_regwr = 0; ia.id_memrd = 0;
        ia.id_src = 0; ia.id_src_use = 0; ia.flush = 0;
        ib.id_valid = 0; ib.id_dst = 0; ib.id_regwr = 0; ib.id_memrd = 0;
        ib.id_src = 0; ib.id_src_use = 0; ib.flush = 0;
        rst_a = 1; rst_b = 1;
        @(posedge clk); @(posedge clk); #1;
        rst_a = 0; rst_b = 0;

        // Default configuration, fwd_sel = {src1, src0} 2 bits each
        step(0, 0, 0, 0, 0, 5'd3, 5'd3, 2'b11, 0, 6'b0000, 0, 0, "a_reset");
        step(0, 1, 3, 1, 0, 5'd1, 5'd2, 2'b11, 0, 6'b0000, 0, 0, "a_add_r3");
        step(0, 1, 4, 1, 0, 5'd3, 5'd3, 2'b11, 0, 6'b0101, 0, 0, "a_use_r3_both");
        step(0, 1, 7, 1, 0, 5'd3, 5'd4, 2'b11, 0, 6'b1001, 0, 0, "a_r3_e1_r4_e0");
        step(0, 1, 7, 1, 0, 5'd0, 5'd0, 2'b11, 0, 6'b0000, 0, 0, "a_r0_src");
        step(0, 1, 0, 1, 0, 5'd7, 5'd7, 2'b11, 0, 6'b0101, 0, 0, "a_youngest_r7");
        step(0, 1, 9, 0, 0, 5'd7, 5'd0, 2'b11, 0, 6'b1000, 0, 0, "a_r0_writer");
        step(0, 1, 10, 0, 0, 5'd7, 5'd9, 2'b11, 0, 6'b0000, 0, 0, "a_noregwr");
        step(0, 1, 5, 1, 1, 5'd0, 5'd0, 2'b11, 0, 6'b0000, 0, 0, "a_lw_r5");
        step(0, 1, 6, 1, 0, 5'd1, 5'd5, 2'b11, 0, 6'b0001, 1, 0, "a_loaduse");
        step(0, 1, 6, 1, 0, 5'd1, 5'd5, 2'b11, 0, 6'b0010, 0, 1, "a_after_stall");
        step(0, 1, 5, 1, 1, 5'd0, 5'd0, 2'b11, 0, 6'b0000, 0, 1, "a_lw_r5_again");
        step(0, 1, 8, 1, 0, 5'd6, 5'd5, 2'b11, 1, 6'b1001, 0, 1, "a_flush");
        step(0, 1, 11, 1, 0, 5'd0, 5'd5, 2'b11, 0, 6'b0010, 0, 1, "a_after_flush");
        step(0, 1, 12, 1, 1, 5'd0, 5'd0, 2'b11, 0, 6'b0000, 0, 1, "a_lw_r12");
        step(0, 0, 13, 1, 0, 5'd0, 5'd12, 2'b01, 0, 6'b0001, 0, 1, "a_invalid_id");
        step(0, 1, 13, 1, 0, 5'd12, 5'd12, 2'b10, 0, 6'b1000, 0, 1, "a_src_use_mask");

        // Deep configuration, fwd_sel = {src1, src0} 3 bits each
        step(1, 0, 0, 0, 0, 5'd0, 5'd0, 2'b11, 0, 6'b000000, 0, 0, "b_reset");
        step(1, 1, 9, 1, 1, 5'd0, 5'd0, 2'b11, 0, 6'b000000, 0, 0, "b_lw_r9");
        c = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 5'(10 + i), 1, 1, 5'd0, 5'(9 + i), 2'b11, 0, 6'b000001, 1, c, "b_stall1");
            c = (c == 3) ? c : c + 1;
            step(1, 1, 5'(10 + i), 1, 1, 5'd0, 5'(9 + i), 2'b11, 0, 6'b000010, 1, c, "b_stall2");
            c = (c == 3) ? c : c + 1;
            step(1, 1, 5'(10 + i), 1, 1, 5'd0, 5'(9 + i), 2'b11, 0, 6'b000011, 0, c, "b_issue");
        end
        step(1, 1, 14, 1, 1, 5'd0, 5'd13, 2'b11, 0, 6'b000001, 1, 3, "b_l5_stall1");
        rst_b = 1;
        step(1, 1, 14, 1, 1, 5'd0, 5'd13, 2'b11, 0, 6'b000010, 1, 3, "b_l5_rst");
        rst_b = 0;
        step(1, 1, 14, 1, 1, 5'd0, 5'd13, 2'b11, 0, 6'b000000, 0, 0, "b_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
